// File: rtl/umi_mem_responder_pkg.sv
// rtl/umi_mem_responder_pkg.sv - UMI widths, responder state enum and beat helper
package umi_mem_responder_pkg;

  localparam int UMI_ADDR_WIDTH = 64;
  localparam int UMI_DATA_WIDTH = 512;
  localparam int UMI_MASK_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_WRITE,
    ST_READ
  } umi_resp_state_e;

  // Beat count wraps in address width, matching the initiator's arithmetic.
  function automatic logic [UMI_ADDR_WIDTH-1:0] beats_of(input logic [UMI_ADDR_WIDTH-1:0] size);
    logic [UMI_ADDR_WIDTH-1:0] padded;
    padded = size + UMI_ADDR_WIDTH'(63);
    return padded >> 6;
  endfunction

endpackage

// File: rtl/umi_resp_ram.sv
// rtl/umi_resp_ram.sv - single-port synchronous RAM with byte enables, 1-cycle read latency
module umi_resp_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 512
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < DATA_W / 8; b++) begin
          if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/umi_mem_responder.sv
// rtl/umi_mem_responder.sv - UMI responder serving requests from on-chip RAM
module umi_mem_responder
  import umi_mem_responder_pkg::*;
#(
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      umi_raise_in,
  input  logic                      umi_write_in,
  input  logic [UMI_ADDR_WIDTH-1:0] umi_addr_in,
  input  logic [UMI_ADDR_WIDTH-1:0] umi_size_in,
  output logic                      umi_grant_out,
  input  logic [UMI_DATA_WIDTH-1:0] umi_wrdata_in,
  input  logic [UMI_MASK_WIDTH-1:0] umi_wrmask_in,
  input  logic                      umi_wren_in,
  output logic                      umi_wrrdy_out,
  output logic [UMI_DATA_WIDTH-1:0] umi_rddata_out,
  output logic                      umi_rdrdy_out,
  input  logic                      umi_rden_in,
  output logic [31:0]               req_count_out
);

  umi_resp_state_e             state;
  logic                        is_write;
  logic [MEM_DEPTH_LOG2-1:0]   index;
  logic [UMI_ADDR_WIDTH-1:0]   remain;
  logic [UMI_ADDR_WIDTH-1:0]   fetch_left;
  logic                        inflight, out_valid, skid_valid;
  logic [UMI_DATA_WIDTH-1:0]   out_data, skid_data, ram_rdata;
  logic [1:0]                  occupancy;
  logic                        fetch, wr_beat, pop;
  logic                        unused_addr;

  assign unused_addr = ^{umi_addr_in[UMI_ADDR_WIDTH-1:6+MEM_DEPTH_LOG2], umi_addr_in[5:0]};

  assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, inflight};
  assign fetch     = (state == ST_READ) && (fetch_left != '0) && (occupancy < 2'd2);
  assign wr_beat   = (state == ST_WRITE) && umi_wren_in;

  // Freshly fetched data is presented straight from the RAM until it is parked.
  assign umi_rdrdy_out  = out_valid || inflight;
  assign umi_rddata_out = out_valid ? out_data : (inflight ? ram_rdata : '0);
  assign pop            = umi_rdrdy_out && umi_rden_in;

  umi_resp_ram #(
    .ADDR_W (MEM_DEPTH_LOG2),
    .DATA_W (UMI_DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (fetch || wr_beat),
    .we    (wr_beat),
    .addr  (index),
    .wdata (umi_wrdata_in),
    .be    (~umi_wrmask_in),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      is_write      <= 1'b0;
      index         <= '0;
      remain        <= '0;
      fetch_left    <= '0;
      umi_grant_out <= 1'b0;
      umi_wrrdy_out <= 1'b0;
      req_count_out <= '0;
      inflight      <= 1'b0;
      out_valid     <= 1'b0;
      skid_valid    <= 1'b0;
      out_data      <= '0;
      skid_data     <= '0;
    end else begin
      umi_grant_out <= 1'b0;
      inflight      <= fetch;
      if (fetch || wr_beat) index <= index + 1'b1;
      if (fetch) fetch_left <= fetch_left - 1'b1;

      // Ordered entries: output register, then skid, then in-flight RAM word.
      if (!out_valid) begin
        if (inflight && !pop) begin
          out_valid <= 1'b1;
          out_data  <= ram_rdata;
        end
      end else if (!skid_valid) begin
        if (pop) begin
          out_valid <= inflight;
          out_data  <= ram_rdata;
        end else if (inflight) begin
          skid_valid <= 1'b1;
          skid_data  <= ram_rdata;
        end
      end else if (pop) begin
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (umi_raise_in) begin
            is_write      <= umi_write_in;
            index         <= umi_addr_in[6 +: MEM_DEPTH_LOG2];
            remain        <= beats_of(umi_size_in);
            fetch_left    <= beats_of(umi_size_in);
            umi_grant_out <= 1'b1;
            state         <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          req_count_out <= req_count_out + 32'd1;
          if (remain == '0) begin
            state <= ST_IDLE;
          end else if (is_write) begin
            umi_wrrdy_out <= 1'b1;
            state         <= ST_WRITE;
          end else begin
            state <= ST_READ;
          end
        end
        ST_WRITE: begin
          if (wr_beat) begin
            remain <= remain - 1'b1;
            if (remain == UMI_ADDR_WIDTH'(1)) begin
              umi_wrrdy_out <= 1'b0;
              state         <= ST_IDLE;
            end
          end
        end
        ST_READ: begin
          if (pop) begin
            remain <= remain - 1'b1;
            if (remain == UMI_ADDR_WIDTH'(1)) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_umi_mem_responder.sv
// tb/tb_umi_mem_responder.sv - vector table, directed corners and random traffic against a word-array model
module tb_umi_mem_responder;
  import umi_mem_responder_pkg::*;

  localparam int DEPTH = 1024;

  logic         clk = 1'b0;
  logic         rst;
  logic         umi_raise_in, umi_write_in, umi_wren_in, umi_rden_in;
  logic [63:0]  umi_addr_in, umi_size_in, umi_wrmask_in;
  logic [511:0] umi_wrdata_in, umi_rddata_out;
  logic         umi_grant_out, umi_wrrdy_out, umi_rdrdy_out;
  logic [31:0]  req_count_out;

  always #5 clk = ~clk;

  umi_mem_responder #(.MEM_DEPTH_LOG2(10)) dut (
    .clk            (clk),
    .rst            (rst),
    .umi_raise_in   (umi_raise_in),
    .umi_write_in   (umi_write_in),
    .umi_addr_in    (umi_addr_in),
    .umi_size_in    (umi_size_in),
    .umi_grant_out  (umi_grant_out),
    .umi_wrdata_in  (umi_wrdata_in),
    .umi_wrmask_in  (umi_wrmask_in),
    .umi_wren_in    (umi_wren_in),
    .umi_wrrdy_out  (umi_wrrdy_out),
    .umi_rddata_out (umi_rddata_out),
    .umi_rdrdy_out  (umi_rdrdy_out),
    .umi_rden_in    (umi_rden_in),
    .req_count_out  (req_count_out)
  );

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [63:0] size;
    logic [63:0] mask;
    int          fill;   // 0 random, 1 all ones, 2 all zeros
    int          beats;
    logic [31:0] pat;
    int          plen;
    int          gap;
  } vec_t;

  logic [511:0] model [DEPTH];
  logic [511:0] last_rd;
  int           errors = 0;
  int           checks = 0;
  logic [31:0]  exp_req;
  vec_t         tv [$];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] make_word(input int fill);
    logic [511:0] w;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
    if (fill == 1) w = '1;
    if (fill == 2) w = '0;
    return w;
  endfunction

  task automatic do_xfer(input vec_t v);
    int idx;
    int n;
    bit rdy_bad;
    idx = int'((v.addr >> 6) % 64'(DEPTH));
    n = 0;
    rdy_bad = 0;
    umi_raise_in = 1'b1;
    umi_write_in = v.wr;
    umi_addr_in  = v.addr;
    umi_size_in  = v.size;
    tick();
    check("grant", 512'(umi_grant_out), 512'(1));
    umi_raise_in = 1'b0;
    exp_req++;
    tick();
    if (v.beats == 0) begin
      check("zero_idle", 512'({umi_grant_out, umi_wrrdy_out, umi_rdrdy_out}), 512'(0));
    end else if (v.wr) begin
      for (int k = 0; n < v.beats && k < 5000; k++) begin
        if (k > 0) tick();
        if (!umi_wrrdy_out) rdy_bad = 1;
        umi_wren_in   = ($urandom_range(99) >= v.gap);
        umi_wrdata_in = make_word(v.fill);
        umi_wrmask_in = v.mask;
        if (umi_wren_in && umi_wrrdy_out) begin
          for (int b = 0; b < 64; b++)
            if (!v.mask[b]) model[idx][b*8 +: 8] = umi_wrdata_in[b*8 +: 8];
          n++;
          idx = (idx + 1) % DEPTH;
        end
      end
      tick();
      umi_wren_in = 1'b0;
      check("wr_beats", 512'(n), 512'(v.beats));
      check("wrrdy_held", 512'(rdy_bad), 512'(0));
      check("wrrdy_drop", 512'(umi_wrrdy_out), 512'(0));
    end else begin
      check("rd_not_early", 512'(umi_rdrdy_out), 512'(0));
      for (int k = 0; n < v.beats && k < 5000; k++) begin
        tick();
        if (k == 0) check("rd_latency", 512'(umi_rdrdy_out), 512'(1));
        umi_rden_in = v.pat[k % v.plen];
        if (umi_rdrdy_out) begin
          check("rd_data", umi_rddata_out, model[idx]);
          if (umi_rden_in) begin
            last_rd = umi_rddata_out;
            n++;
            idx = (idx + 1) % DEPTH;
          end
        end
      end
      tick();
      umi_rden_in = 1'b0;
      check("rd_beats", 512'(n), 512'(v.beats));
      check("rdrdy_drop", 512'(umi_rdrdy_out), 512'(0));
    end
    check("req_count", 512'(req_count_out), 512'(exp_req));
  endtask

  function automatic vec_t mk(input bit wr, input logic [63:0] addr, input logic [63:0] size,
                              input logic [63:0] mask, input int fill, input int beats,
                              input logic [31:0] pat, input int plen, input int gap);
    vec_t v;
    v.wr = wr; v.addr = addr; v.size = size; v.mask = mask; v.fill = fill;
    v.beats = beats; v.pat = pat; v.plen = plen; v.gap = gap;
    return v;
  endfunction

  initial begin
    vec_t v;
    rst = 1'b1;
    umi_raise_in = 0; umi_write_in = 0; umi_addr_in = 0; umi_size_in = 0;
    umi_wrdata_in = 0; umi_wrmask_in = 0; umi_wren_in = 0; umi_rden_in = 0;
    exp_req = 0;
    repeat (3) tick();
    check("rst_grant", 512'(umi_grant_out), 512'(0));
    check("rst_wrrdy", 512'(umi_wrrdy_out), 512'(0));
    check("rst_rdrdy", 512'(umi_rdrdy_out), 512'(0));
    check("rst_rddata", umi_rddata_out, 512'(0));
    check("rst_count", 512'(req_count_out), 512'(0));
    rst = 1'b0;
    tick();

    tv.push_back(mk(1, 64'h80, 128, 0, 0, 2, 0, 1, 0));
    tv.push_back(mk(0, 64'h80, 128, 0, 0, 2, 1, 1, 0));
    tv.push_back(mk(1, 64'h0, 65536, 0, 0, 1024, 0, 1, 0));
    tv.push_back(mk(0, 64'h100, 256, 0, 0, 4, 32'b1011001, 7, 0));
    tv.push_back(mk(1, 64'hFFC0, 128, 0, 0, 2, 0, 1, 20));
    tv.push_back(mk(0, 64'hFFC0, 128, 0, 0, 2, 1, 1, 0));
    tv.push_back(mk(0, 64'h0, 64, 0, 0, 1, 1, 1, 0));
    tv.push_back(mk(0, 64'hABCD_0000_0001_FFC0, 128, 0, 0, 2, 32'b01, 2, 0));
    tv.push_back(mk(1, 64'h0, 0, 0, 0, 0, 0, 1, 0));
    tv.push_back(mk(0, 64'h0, 0, 0, 0, 0, 1, 1, 0));
    tv.push_back(mk(1, 64'h40, 65, 0, 0, 2, 0, 1, 0));
    tv.push_back(mk(0, 64'h40, 65, 0, 0, 2, 32'b110, 3, 0));
    for (int i = 0; i < tv.size(); i++) do_xfer(tv[i]);

    // Byte mask: low 16 bytes suppressed on the second write keep their ones.
    do_xfer(mk(1, 64'h0, 64, 0, 1, 1, 0, 1, 0));
    do_xfer(mk(1, 64'h0, 64, 64'h0000_0000_0000_FFFF, 2, 1, 0, 1, 0));
    do_xfer(mk(0, 64'h0, 64, 0, 0, 1, 1, 1, 0));
    check("mask_word0", last_rd, {{384{1'b0}}, {128{1'b1}}});

    for (int i = 0; i < 40; i++) begin
      v.wr    = $urandom_range(1);
      v.addr  = {$urandom, $urandom};
      v.size  = 64'($urandom_range(320));
      v.mask  = ($urandom_range(3) == 0) ? {$urandom, $urandom} : 64'h0;
      v.fill  = 0;
      v.beats = int'((v.size + 63) / 64);
      v.pat   = $urandom;
      v.plen  = 32;
      v.gap   = 30;
      do_xfer(v);
    end

    // Reset while the second beat of a 4-beat read is on the output.
    umi_raise_in = 1; umi_write_in = 0; umi_addr_in = 64'h200; umi_size_in = 256;
    tick();
    umi_raise_in = 0;
    tick();
    tick();
    check("rr_first", 512'(umi_rdrdy_out), 512'(1));
    umi_rden_in = 1;
    tick();
    umi_rden_in = 0;
    check("rr_second", 512'(umi_rdrdy_out), 512'(1));
    rst = 1;
    tick();
    check("rr_grant", 512'(umi_grant_out), 512'(0));
    check("rr_wrrdy", 512'(umi_wrrdy_out), 512'(0));
    check("rr_rdrdy", 512'(umi_rdrdy_out), 512'(0));
    check("rr_rddata", umi_rddata_out, 512'(0));
    check("rr_count", 512'(req_count_out), 512'(0));
    rst = 0;
    exp_req = 0;
    tick();
    do_xfer(mk(0, 64'h200, 128, 0, 0, 2, 1, 1, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
